// File: rtl/lcd_frame_writer_pkg.sv
// lcd_pkg: shared constants for the HD44780 frame writer.
//   - command bytes for the init sequence and line base addresses
//   - FSM state encoding
//   - text_char(): pick one column byte out of a packed 16-char line
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0E;
  localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_LINE1_BASE   = 8'h80;
  localparam logic [7:0] LCD_LINE2_BASE   = 8'hC0;

  typedef enum logic [3:0] {
    ST_POWER_WAIT = 4'd0,
    ST_FUNC_SET   = 4'd1,
    ST_DISP_ON    = 4'd2,
    ST_ENTRY_MODE = 4'd3,
    ST_CLEAR      = 4'd4,
    ST_CLEAR_WAIT = 4'd5,
    ST_LINE1_ADDR = 4'd6,
    ST_LINE1      = 4'd7,
    ST_LINE2_ADDR = 4'd8,
    ST_LINE2      = 4'd9,
    ST_CURSOR     = 4'd10
  } lcd_state_t;

  // Column 0 sits in the top byte, column 15 in the bottom byte, so the
  // right shift for column c is 8*(15-c) = {~c, 3'b000}.
  function automatic logic [7:0] text_char(input logic [127:0] text, input logic [3:0] col);
    return 8'(text >> {~col, 3'b000});
  endfunction

endpackage

// File: rtl/lcd_frame_writer_if.sv
// lcd_frame_writer_if: groups the text inputs and LCD bus outputs.
//   line1_text/line2_text (128b each), ddram_address (7b)  -> writer
//   lcd_e, lcd_rs, lcd_rw, lcd_data (8b), frame_done        <- writer
// master = the frame writer, slave = whoever supplies text and watches the bus.
interface lcd_frame_writer_if;
  logic [127:0] line1_text;
  logic [127:0] line2_text;
  logic [6:0]   ddram_address;
  logic         lcd_e;
  logic         lcd_rs;
  logic         lcd_rw;
  logic [7:0]   lcd_data;
  logic         frame_done;

  modport master (
    input  line1_text, line2_text, ddram_address,
    output lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
  );

  modport slave (
    output line1_text, line2_text, ddram_address,
    input  lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
  );
endinterface

// File: rtl/lcd_frame_writer_step_timer.sv
// lcd_step_timer: free-running step counter 0..STEP_CYCLES-1.
//   clk, rst (async active-low)
//   step_end   : high on the last clk of every step
//   step_start : high on the first clk of every step
//   e_window   : high while the counter is in [STEP_CYCLES/4, 3*STEP_CYCLES/4)
module lcd_step_timer #(
  parameter int STEP_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  output logic step_end,
  output logic step_start,
  output logic e_window
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] E_ON  = CW'(STEP_CYCLES / 4);
  localparam logic [CW-1:0] E_OFF = CW'((3 * STEP_CYCLES) / 4);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (step_end) cnt <= '0;
    else               cnt <= cnt + CW'(1);
  end

  assign step_end   = (cnt == LAST);
  assign step_start = (cnt == '0);
  assign e_window   = (cnt >= E_ON) && (cnt < E_OFF);

endmodule

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: continuous refresh of a 16x2 HD44780 panel, 8-bit write-only.
//   clk, rst (async active-low)
//   bus.line1_text/line2_text/ddram_address : text and cursor position, snapshotted per frame
//   bus.lcd_e/lcd_rs/lcd_rw/lcd_data        : panel bus
//   bus.frame_done                          : 1-clk pulse on the last clk of the CURSOR step
//
// state       | meaning
// POWER_WAIT  | INIT_STEPS idle steps after reset
// FUNC_SET    | cmd 38: 8-bit, 2 lines
// DISP_ON     | cmd 0E: display + cursor on
// ENTRY_MODE  | cmd 06: auto-increment
// CLEAR       | cmd 01
// CLEAR_WAIT  | CLEAR_WAIT_STEPS idle steps for the slow clear
// LINE1_ADDR  | cmd 80; inputs snapshotted on its first clk
// LINE1       | 16 data steps of row 0
// LINE2_ADDR  | cmd C0
// LINE2       | 16 data steps of row 1
// CURSOR      | cmd {1, ddram_snap}; frame_done on last clk, then back to LINE1_ADDR
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int STEP_CYCLES      = 50,
  parameter int INIT_STEPS       = 40,
  parameter int CLEAR_WAIT_STEPS = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  lcd_frame_writer_if.master   bus
);

  localparam int IDLE_MAX = (INIT_STEPS > CLEAR_WAIT_STEPS) ? INIT_STEPS : CLEAR_WAIT_STEPS;
  localparam int IW       = $clog2(IDLE_MAX + 1);

  lcd_state_t   state, state_nxt;
  logic [IW-1:0] idle_cnt, idle_nxt;
  logic [3:0]   col_idx, col_nxt;
  logic [127:0] line1_snap, line2_snap;
  logic [6:0]   ddram_snap;
  logic         rs_q, step_rs;
  logic [7:0]   data_q, step_data;
  logic         step_end, step_start, e_window;
  logic         is_idle;

  lcd_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .step_end   (step_end),
    .step_start (step_start),
    .e_window   (e_window)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_POWER_WAIT;
    else      state <= state_nxt;
  end

  // next state plus the per-step counters that steer it
  always_comb begin
    state_nxt = state;
    if (step_end) begin
      unique case (state)
        ST_POWER_WAIT: if (idle_cnt == IW'(INIT_STEPS - 1)) state_nxt = ST_FUNC_SET;
        ST_FUNC_SET:   state_nxt = ST_DISP_ON;
        ST_DISP_ON:    state_nxt = ST_ENTRY_MODE;
        ST_ENTRY_MODE: state_nxt = ST_CLEAR;
        ST_CLEAR:      state_nxt = ST_CLEAR_WAIT;
        ST_CLEAR_WAIT: if (idle_cnt == IW'(CLEAR_WAIT_STEPS - 1)) state_nxt = ST_LINE1_ADDR;
        ST_LINE1_ADDR: state_nxt = ST_LINE1;
        ST_LINE1:      if (col_idx == 4'hF) state_nxt = ST_LINE2_ADDR;
        ST_LINE2_ADDR: state_nxt = ST_LINE2;
        ST_LINE2:      if (col_idx == 4'hF) state_nxt = ST_CURSOR;
        ST_CURSOR:     state_nxt = ST_LINE1_ADDR;
        default:       state_nxt = ST_POWER_WAIT;
      endcase
    end

    idle_nxt = idle_cnt;
    col_nxt  = col_idx;
    if (step_end) begin
      if (state_nxt != state) begin
        idle_nxt = '0;
        col_nxt  = '0;
      end else begin
        idle_nxt = idle_cnt + IW'(1);
        col_nxt  = col_idx + 4'd1;
      end
    end
  end

  // outputs: bus strobes for the current step, and the byte for the next step
  always_comb begin
    is_idle   = (state == ST_POWER_WAIT) || (state == ST_CLEAR_WAIT);
    step_rs   = 1'b0;
    step_data = 8'h00;
    unique case (state_nxt)
      ST_FUNC_SET:   step_data = LCD_CMD_FUNC_SET;
      ST_DISP_ON:    step_data = LCD_CMD_DISP_ON;
      ST_ENTRY_MODE: step_data = LCD_CMD_ENTRY;
      ST_CLEAR:      step_data = LCD_CMD_CLEAR;
      ST_LINE1_ADDR: step_data = LCD_LINE1_BASE;
      ST_LINE1: begin
        step_rs   = 1'b1;
        step_data = text_char(line1_snap, col_nxt);
      end
      ST_LINE2_ADDR: step_data = LCD_LINE2_BASE;
      ST_LINE2: begin
        step_rs   = 1'b1;
        step_data = text_char(line2_snap, col_nxt);
      end
      ST_CURSOR:     step_data = {1'b1, ddram_snap};
      default:       step_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
      col_idx  <= '0;
    end else begin
      idle_cnt <= idle_nxt;
      col_idx  <= col_nxt;
    end
  end

  // Snapshot on the first clk of LINE1_ADDR; LINE1 column 0 is loaded at the
  // end of that step, so the whole frame reads one consistent copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line1_snap <= {16{8'h20}};
      line2_snap <= {16{8'h20}};
      ddram_snap <= '0;
    end else if (state == ST_LINE1_ADDR && step_start) begin
      line1_snap <= bus.line1_text;
      line2_snap <= bus.line2_text;
      ddram_snap <= bus.ddram_address;
    end
  end

  // rs/data change only at step boundaries so they bracket the e pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else if (step_end) begin
      rs_q   <= step_rs;
      data_q <= step_data;
    end
  end

  assign bus.lcd_e      = e_window && !is_idle;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_data   = data_q;
  assign bus.frame_done = (state == ST_CURSOR) && step_end;

endmodule

// File: tb/tb_lcd_frame_writer.sv
module tb_lcd_frame_writer;
  localparam int SC    = 8;
  localparam int IS    = 2;
  localparam int CWS   = 1;
  localparam int FRAME = 35;
  localparam int FCYC  = FRAME * SC;
  localparam int INITC = (IS + 4 + CWS) * SC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_frame_writer_if bus();

  lcd_frame_writer #(.STEP_CYCLES(SC), .INIT_STEPS(IS), .CLEAR_WAIT_STEPS(CWS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;
  int t = 0;
  int fd_count = 0;
  int last_fd = -1;
  int cur = 0;
  logic [127:0] snap1, snap2;
  logic [6:0]   snapa;
  logic [7:0]   init_cmds [4] = '{8'h38, 8'h0E, 8'h06, 8'h01};

  // What the bus must show on cycle tt after reset release, from the frame schedule.
  task automatic expect_at(input int tt, output logic e, output logic rs,
                           output logic [7:0] d, output logic fd);
    int s, p, pos;
    bit cmd;
    s = tt / SC;
    p = tt % SC;
    e = 1'b0; rs = 1'b0; d = 8'h00; fd = 1'b0; cmd = 1'b0;
    if (s < IS) begin
      cmd = 1'b0;
    end else if (s < IS + 4) begin
      cmd = 1'b1;
      d = init_cmds[s - IS];
    end else if (s >= IS + 4 + CWS) begin
      cmd = 1'b1;
      pos = (s - IS - 4 - CWS) % FRAME;
      if (pos == 0)       d = 8'h80;
      else if (pos <= 16) begin rs = 1'b1; d = snap1[127 - 8*(pos-1) -: 8]; end
      else if (pos == 17) d = 8'hC0;
      else if (pos <= 33) begin rs = 1'b1; d = snap2[127 - 8*(pos-18) -: 8]; end
      else begin
        d = {1'b1, snapa};
        fd = (p == SC - 1);
      end
    end
    e = cmd && (p >= SC/4) && (p < 3*SC/4);
  endtask

  always @(negedge clk) begin
    logic xe, xrs, xfd;
    logic [7:0] xd;
    if (!model_on) begin
      t = 0;
      last_fd = -1;
    end else begin
      if (t >= INITC && ((t - INITC) % FCYC) == 0) begin
        snap1 = bus.line1_text;
        snap2 = bus.line2_text;
        snapa = bus.ddram_address;
      end
      expect_at(t, xe, xrs, xd, xfd);
      n_cmp++;
      if (bus.lcd_e !== xe || bus.lcd_rs !== xrs || bus.lcd_data !== xd ||
          bus.frame_done !== xfd || bus.lcd_rw !== 1'b0) begin
        n_bad++;
        $display("FAIL cycle t=%0d: got e=%b rs=%b data=%h fd=%b rw=%b, expected e=%b rs=%b data=%h fd=%b rw=0",
                 t, bus.lcd_e, bus.lcd_rs, bus.lcd_data, bus.frame_done, bus.lcd_rw, xe, xrs, xd, xfd);
      end
      if (bus.frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          n_cmp++;
          if (t - last_fd != FCYC) begin
            n_bad++;
            $display("FAIL fd_spacing: got %0d expected %0d", t - last_fd, FCYC);
          end
        end
        last_fd = t;
        fd_count++;
      end
      t++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go(input int target);
    if (target < cur) begin
      n_cmp++;
      n_bad++;
      $display("FAIL schedule: target %0d before current %0d", target, cur);
    end else begin
      repeat (target - cur) @(posedge clk);
      #1;
      cur = target;
    end
  endtask

  function automatic logic [127:0] pack16(input string s);
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) v = {v[119:0], 8'(s[i])};
    return v;
  endfunction

  task automatic check_init(input string tag);
    go(15); chk({tag, "_pw_e"},   32'(bus.lcd_e), 0);
    go(18); chk({tag, "_fs_e"},   32'(bus.lcd_e), 1);
            chk({tag, "_fs_d"},   32'(bus.lcd_data), 32'h38);
            chk({tag, "_fs_rs"},  32'(bus.lcd_rs), 0);
    go(22); chk({tag, "_fs_eoff"},32'(bus.lcd_e), 0);
    go(27); chk({tag, "_don_d"},  32'(bus.lcd_data), 32'h0E);
    go(35); chk({tag, "_ent_d"},  32'(bus.lcd_data), 32'h06);
    go(43); chk({tag, "_clr_d"},  32'(bus.lcd_data), 32'h01);
    go(51); chk({tag, "_cw_e"},   32'(bus.lcd_e), 0);
    go(59); chk({tag, "_l1a_d"},  32'(bus.lcd_data), 32'h80);
  endtask

  initial begin
    bus.line1_text    = pack16("HELLO WORLD     ");
    bus.line2_text    = pack16("0123456789ABCDEF");
    bus.ddram_address = 7'h45;
    #3 rst = 1'b0;
    #1;
    chk("rst_e",  32'(bus.lcd_e), 0);
    chk("rst_rs", 32'(bus.lcd_rs), 0);
    chk("rst_d",  32'(bus.lcd_data), 0);
    chk("rst_fd", 32'(bus.frame_done), 0);
    chk("rst_rw", 32'(bus.lcd_rw), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; model_on = 1'b1; cur = 0;

    check_init("init1");
    go(67);  chk("f0_col0", 32'(bus.lcd_data), 32'h48);
             chk("f0_rs",   32'(bus.lcd_rs), 1);
    go(107); chk("f0_col5", 32'(bus.lcd_data), 32'h20);
    bus.line1_text    = {16{8'h58}};
    bus.ddram_address = 7'h0F;
    go(115); chk("f0_col6", 32'(bus.lcd_data), 32'h57);
    go(203); chk("f0_l2c0", 32'(bus.lcd_data), 32'h30);
    go(331); chk("f0_cur",  32'(bus.lcd_data), 32'hC5);
    go(334); chk("f0_fd_pre", 32'(bus.frame_done), 0);
    go(335); chk("f0_fd",   32'(bus.frame_done), 1);
    go(347); chk("f1_col0", 32'(bus.lcd_data), 32'h58);
    bus.ddram_address = 7'h40;
    go(611); chk("f1_cur",  32'(bus.lcd_data), 32'h8F);
    go(891); chk("f2_cur",  32'(bus.lcd_data), 32'hC0);

    for (int f = 3; f < 6; f++) begin
      go(INITC + FCYC*f + int'($urandom_range(0, FCYC - 1)));
      bus.line1_text    = {$urandom, $urandom, $urandom, $urandom};
      bus.line2_text    = {$urandom, $urandom, $urandom, $urandom};
      bus.ddram_address = 7'($urandom_range(0, 127));
    end

    // reset while e is high in frame 6, LINE2 column 3
    go(INITC + FCYC*6 + 21*SC + 3);
    chk("pre_rst_e",  32'(bus.lcd_e), 1);
    chk("pre_rst_rs", 32'(bus.lcd_rs), 1);
    model_on = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_e",  32'(bus.lcd_e), 0);
    chk("mid_rst_rs", 32'(bus.lcd_rs), 0);
    chk("mid_rst_d",  32'(bus.lcd_data), 0);
    chk("mid_rst_fd", 32'(bus.frame_done), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; model_on = 1'b1; cur = 0;

    check_init("init2");
    go(INITC + FCYC + 10);
    chk("fd_count", 32'(fd_count), 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
